// File: rtl/vram_arbiter.sv
// VRAM port arbiter: readout fetches own fixed slots (counts 2 and 6), host writes
// drain through a small FIFO in free slots, host reads are single-outstanding.
module vram_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          active,
    input  logic [2:0]                    readoutCount,
    input  logic [ADDR_W-1:0]             readoutAddr,
    output logic [DATA_W-1:0]             readoutData,
    input  logic                          hostWrReq,
    input  logic [ADDR_W-1:0]             hostWrAddr,
    input  logic [DATA_W-1:0]             hostWrData,
    output logic                          hostWrRdy,
    input  logic                          hostRdReq,
    input  logic [ADDR_W-1:0]             hostRdAddr,
    output logic                          hostRdBusy,
    output logic                          hostRdValid,
    output logic [DATA_W-1:0]             hostRdData,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic [ADDR_W-1:0]             ramAddr,
    output logic                          ramWrEn,
    output logic [DATA_W-1:0]             ramWrData,
    input  logic [DATA_W-1:0]             ramRdData
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAPT = 2'd2
    } rd_state_e;

    rd_state_e            rd_state_q, rd_state_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [ADDR_W-1:0]    fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]    fifo_addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data_d [FIFO_DEPTH];

    logic rsv_slot;
    logic fifo_empty;
    logic fifo_full;
    logic rd_issue;
    logic wr_pop;
    logic wr_push;

    // Slot ownership: reserved fetch, then pending read (only once writes drained), then FIFO pop
    always_comb begin
        rsv_slot   = active && ((readoutCount == 3'd2) || (readoutCount == 3'd6));
        fifo_empty = (level_q == LVL_W'(0));
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        rd_issue   = !rsv_slot && (rd_state_q == RD_WAIT) && fifo_empty;
        wr_pop     = !rsv_slot && !fifo_empty && !rd_issue;
        hostWrRdy  = nrst && !fifo_full && (rd_state_q == RD_IDLE);
        wr_push    = hostWrReq && hostWrRdy;
    end

    // VRAM port mux
    always_comb begin
        ramWrEn   = nrst && wr_pop;
        ramAddr   = readoutAddr;
        ramWrData = {DATA_W{1'b0}};
        if (rd_issue) begin
            ramAddr = rd_addr_q;
        end else if (wr_pop) begin
            ramAddr   = fifo_addr_q[rd_ptr_q];
            ramWrData = fifo_data_q[rd_ptr_q];
        end else begin
            ramAddr = readoutAddr;
        end
    end

    // Write FIFO next state; pointers wrap naturally since depth is a power of two
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        if (wr_push) begin
            fifo_addr_d[wr_ptr_q] = hostWrAddr;
            fifo_data_d[wr_ptr_q] = hostWrData;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (wr_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_push, wr_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Host read FSM next state
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (hostRdReq) begin
                    rd_addr_d  = hostRdAddr;
                    rd_state_d = RD_WAIT;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_WAIT: begin
                if (rd_issue) begin
                    rd_state_d = RD_CAPT;
                end else begin
                    rd_state_d = RD_WAIT;
                end
            end
            RD_CAPT: begin
                rd_data_d  = ramRdData;
                rd_valid_d = 1'b1;
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // State registers; reset discards queued writes and aborts a pending read
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_state_q  <= RD_IDLE;
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_valid_q  <= 1'b0;
            rd_data_q   <= {DATA_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            fifo_addr_q <= '{default: {ADDR_W{1'b0}}};
            fifo_data_q <= '{default: {DATA_W{1'b0}}};
        end else begin
            rd_state_q  <= rd_state_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign readoutData = ramRdData;
    assign hostRdBusy  = (rd_state_q != RD_IDLE);
    assign hostRdValid = rd_valid_q;
    assign hostRdData  = rd_data_q;
    assign fifoLevel   = level_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              active = 1'b0;
    logic [2:0]        readoutCount = 3'd0;
    logic [ADDR_W-1:0] readoutAddr = '0;
    logic [DATA_W-1:0] readoutData;
    logic              hostWrReq = 1'b0;
    logic [ADDR_W-1:0] hostWrAddr = '0;
    logic [DATA_W-1:0] hostWrData = '0;
    logic              hostWrRdy;
    logic              hostRdReq = 1'b0;
    logic [ADDR_W-1:0] hostRdAddr = '0;
    logic              hostRdBusy;
    logic              hostRdValid;
    logic [DATA_W-1:0] hostRdData;
    logic [$clog2(DEPTH):0] fifoLevel;
    logic [ADDR_W-1:0] ramAddr;
    logic              ramWrEn;
    logic [DATA_W-1:0] ramWrData;
    logic [DATA_W-1:0] ramRdData = '0;

    int checks = 0;
    int errors = 0;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .active(active), .readoutCount(readoutCount),
        .readoutAddr(readoutAddr), .readoutData(readoutData),
        .hostWrReq(hostWrReq), .hostWrAddr(hostWrAddr), .hostWrData(hostWrData),
        .hostWrRdy(hostWrRdy), .hostRdReq(hostRdReq), .hostRdAddr(hostRdAddr),
        .hostRdBusy(hostRdBusy), .hostRdValid(hostRdValid), .hostRdData(hostRdData),
        .fifoLevel(fifoLevel), .ramAddr(ramAddr), .ramWrEn(ramWrEn),
        .ramWrData(ramWrData), .ramRdData(ramRdData)
    );

    always #5 clk = ~clk;

    // Environment VRAM (driven by what the DUT actually does) and the model's own copy
    logic [DATA_W-1:0] vram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        ramRdData <= vram[ramAddr];
        if (ramWrEn) vram[ramAddr] <= ramWrData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: write queue, pending-read flags, shadow memory
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               wq[$];
    bit                m_pend = 1'b0;
    bit                m_capt = 1'b0;
    bit                m_valid = 1'b0;
    bit                m_known = 1'b0;
    logic [ADDR_W-1:0] m_raddr = '0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [DATA_W-1:0] m_last = '0;

    always @(negedge clk) begin : model_p
        bit                rsv, busy, rdy, issue, pop;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] nxt_last;
        if (!nrst) begin
            check("rst_ramWrEn", 32'(ramWrEn), 32'(0));
            check("rst_hostWrRdy", 32'(hostWrRdy), 32'(0));
            wq.delete();
            m_pend  = 1'b0;
            m_capt  = 1'b0;
            m_valid = 1'b0;
            m_rdata = '0;
            m_known = 1'b0;
        end else begin
            rsv   = active && (readoutCount == 3'd2 || readoutCount == 3'd6);
            busy  = m_pend || m_capt;
            rdy   = (wq.size() < DEPTH) && !busy;
            issue = 1'b0;
            pop   = 1'b0;
            ea    = readoutAddr;
            if (!rsv) begin
                if (m_pend && wq.size() == 0) begin
                    issue = 1'b1;
                    ea    = m_raddr;
                end else if (wq.size() != 0) begin
                    pop = 1'b1;
                    ea  = wq[0].a;
                end
            end
            check("ramAddr", 32'(ramAddr), 32'(ea));
            check("ramWrEn", 32'(ramWrEn), 32'(pop));
            if (pop) check("ramWrData", 32'(ramWrData), 32'(wq[0].d));
            check("hostWrRdy", 32'(hostWrRdy), 32'(rdy));
            check("hostRdBusy", 32'(hostRdBusy), 32'(busy));
            check("fifoLevel", 32'(fifoLevel), 32'(wq.size()));
            check("hostRdValid", 32'(hostRdValid), 32'(m_valid));
            check("hostRdData", 32'(hostRdData), 32'(m_rdata));
            if (m_known) check("readoutData", 32'(readoutData), 32'(m_last));
            nxt_last = ref_mem[ea];
            if (pop) ref_mem[ea] = wq[0].d;
            if (m_capt) m_rdata = m_last;
            m_valid = m_capt;
            m_capt  = issue;
            if (issue) m_pend = 1'b0;
            if (pop) void'(wq.pop_front());
            if (hostWrReq && rdy) wq.push_back({hostWrAddr, hostWrData});
            if (!busy && hostRdReq) begin
                m_pend  = 1'b1;
                m_raddr = hostRdAddr;
            end
            m_last  = nxt_last;
            m_known = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, input logic [DATA_W-1:0] exp);
        int n = 0;
        while (!hostRdValid && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_valid"}, 32'(hostRdValid), 32'(1));
        check({nm, "_data"}, 32'(hostRdData), 32'(exp));
        tick();
        check({nm, "_single_pulse"}, 32'(hostRdValid), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            vram[i]    = 8'($urandom);
            ref_mem[i] = vram[i];
        end
        vram[13'h050] = 8'hC3;  ref_mem[13'h050] = 8'hC3;
        vram[13'h200] = 8'h99;  ref_mem[13'h200] = 8'h99;

        // Reset and idle
        repeat (3) tick();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("idle_level", 32'(fifoLevel), 32'(0));
            check("idle_wrrdy", 32'(hostWrRdy), 32'(1));
            check("idle_busy", 32'(hostRdBusy), 32'(0));
            check("idle_wren", 32'(ramWrEn), 32'(0));
            tick();
        end

        // Write pushed in a reserved slot lands in the following free slot
        active = 1'b1; readoutCount = 3'd2; readoutAddr = 13'h1AB;
        hostWrReq = 1'b1; hostWrAddr = 13'h010; hostWrData = 8'h41;
        mid();
        check("rsv_addr", 32'(ramAddr), 32'(13'h1AB));
        check("rsv_wren", 32'(ramWrEn), 32'(0));
        tick();
        hostWrReq = 1'b0; readoutCount = 3'd3;
        mid();
        check("free_addr", 32'(ramAddr), 32'(13'h010));
        check("free_data", 32'(ramWrData), 32'(8'h41));
        check("free_wren", 32'(ramWrEn), 32'(1));
        tick();

        // Fill the FIFO under continuous reserved slots, then drain in order
        readoutCount = 3'd2;
        for (int i = 0; i < 6; i++) begin
            hostWrReq  = (i < 5);
            hostWrAddr = 13'(13'h100 + i);
            hostWrData = 8'(8'h80 + i);
            mid();
            check("fill_wrrdy", 32'(hostWrRdy), 32'(i < 4));
            check("fill_level", 32'(fifoLevel), 32'((i < 4) ? i : 4));
            tick();
        end
        hostWrReq = 1'b0; active = 1'b0; readoutCount = 3'd3;
        for (int j = 0; j < 4; j++) begin
            mid();
            check("drain_wren", 32'(ramWrEn), 32'(1));
            check("drain_addr", 32'(ramAddr), 32'(13'h100 + j));
            check("drain_data", 32'(ramWrData), 32'(8'h80 + j));
            tick();
        end
        mid();
        check("drained_level", 32'(fifoLevel), 32'(0));
        tick();

        // Same-edge write and read of one address: write goes first
        hostWrReq = 1'b1; hostWrAddr = 13'h123; hostWrData = 8'h5A;
        hostRdReq = 1'b1; hostRdAddr = 13'h123;
        tick();
        hostWrReq = 1'b0; hostRdReq = 1'b0;
        mid();
        check("same_wr_first", 32'(ramWrEn), 32'(1));
        check("same_wr_addr", 32'(ramAddr), 32'(13'h123));
        tick();
        mid();
        check("same_rd_wren", 32'(ramWrEn), 32'(0));
        check("same_rd_addr", 32'(ramAddr), 32'(13'h123));
        wait_valid("same_rd", 8'h5A);

        // Read accepted during a reserved slot issues at count 3
        active = 1'b1; readoutCount = 3'd2; readoutAddr = 13'h0777;
        hostRdReq = 1'b1; hostRdAddr = 13'h050;
        mid();
        check("defer_rsv_addr", 32'(ramAddr), 32'(13'h0777));
        tick();
        hostRdReq = 1'b0; readoutCount = 3'd3;
        mid();
        check("defer_rd_addr", 32'(ramAddr), 32'(13'h050));
        check("defer_rd_wren", 32'(ramWrEn), 32'(0));
        tick();
        readoutCount = 3'd4;
        wait_valid("defer_rd", 8'hC3);

        // Reset while a read waits behind two queued writes
        readoutCount = 3'd2;
        hostWrReq = 1'b1; hostWrAddr = 13'h200; hostWrData = 8'h11;
        tick();
        hostWrAddr = 13'h201; hostWrData = 8'h22;
        hostRdReq = 1'b1; hostRdAddr = 13'h050;
        tick();
        hostWrReq = 1'b0; hostRdReq = 1'b0;
        mid();
        check("pre_rst_level", 32'(fifoLevel), 32'(2));
        check("pre_rst_busy", 32'(hostRdBusy), 32'(1));
        tick();
        nrst = 1'b0; active = 1'b0; readoutCount = 3'd0;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("in_rst_wren", 32'(ramWrEn), 32'(0));
            check("in_rst_valid", 32'(hostRdValid), 32'(0));
            tick();
        end
        nrst = 1'b1;
        mid();
        check("post_rst_level", 32'(fifoLevel), 32'(0));
        check("post_rst_wrrdy", 32'(hostWrRdy), 32'(1));
        check("post_rst_busy", 32'(hostRdBusy), 32'(0));
        check("post_rst_valid", 32'(hostRdValid), 32'(0));
        tick();
        hostRdReq = 1'b1; hostRdAddr = 13'h200;
        tick();
        hostRdReq = 1'b0;
        wait_valid("discarded_wr", 8'h99);
        hostRdReq = 1'b1; hostRdAddr = 13'h010;
        tick();
        hostRdReq = 1'b0;
        wait_valid("post_rst_rd", 8'h41);

        // Randomized traffic over a small address window to force collisions
        for (int c = 0; c < 3000; c++) begin
            readoutCount = readoutCount + 3'd1;
            if ($urandom_range(0, 63) == 0) active = ~active;
            readoutAddr = 13'($urandom_range(0, 63));
            hostWrReq   = ($urandom_range(0, 2) == 0);
            hostWrAddr  = 13'($urandom_range(0, 31));
            hostWrData  = 8'($urandom);
            hostRdReq   = ($urandom_range(0, 5) == 0);
            hostRdAddr  = 13'($urandom_range(0, 31));
            nrst        = ($urandom_range(0, 499) != 0);
            tick();
        end
        nrst = 1'b1; hostWrReq = 1'b0; hostRdReq = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
